// File: rtl/tidc_l1_probe_agent.sv
`default_nettype none
// ============================================================================
// Module   : tidc_l1_probe_agent
// Brief    : L1 probe responder for the TIDC hub. Tracks a direct-mapped line
//            table and answers probes with shrink/report parameter and dirty data.
// Revision : 1.0 - initial release
// ============================================================================
module tidc_l1_probe_agent #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 512,
  parameter int OFFSET_W = 6,
  parameter int IDX_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fill_valid_i,
  output logic              fill_ready_o,
  input  logic [ADDR_W-1:0] fill_addr_i,
  input  logic [DATA_W-1:0] fill_data_i,
  input  logic              fill_perm_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_hit_o,
  input  logic              probe_req_valid_i,
  output logic              probe_req_ready_o,
  input  logic [ADDR_W-1:0] probe_req_addr_i,
  input  logic [2:0]        probe_req_permissions_i,
  output logic              probe_ack_valid_o,
  input  logic              probe_ack_ready_i,
  output logic [ADDR_W-1:0] probe_ack_addr_o,
  output logic [2:0]        probe_ack_permissions_o,
  output logic              probe_ack_has_data_o,
  output logic [DATA_W-1:0] probe_ack_dirty_data_o
);

  localparam int SETS   = 1 << IDX_W;
  localparam int TAG_W  = ADDR_W - OFFSET_W - IDX_W;
  localparam int LINE_W = ADDR_W - OFFSET_W;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_ACK    = 2'd2;

  localparam logic [2:0] PARAM_TTOB = 3'd0;
  localparam logic [2:0] PARAM_TTON = 3'd1;
  localparam logic [2:0] PARAM_BTON = 3'd2;
  localparam logic [2:0] PARAM_TTOT = 3'd3;
  localparam logic [2:0] PARAM_BTOB = 3'd4;
  localparam logic [2:0] PARAM_NTON = 3'd5;

  logic [1:0]        state_q, state_d;
  logic [LINE_W-1:0] pline_q;
  logic [2:0]        pcap_q;
  logic [ADDR_W-1:0] ack_addr_q;
  logic [2:0]        ack_perm_q;
  logic              ack_has_q;
  logic [DATA_W-1:0] ack_data_q;
  logic              dg_inval_q, dg_tob_q, dg_clean_q;
  logic              wr_hit_q;

  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q   [SETS];
  logic              perm_q  [SETS];
  logic              dirty_q [SETS];
  logic [DATA_W-1:0] data_q  [SETS];

  logic [IDX_W-1:0]  fill_idx, wr_idx, p_idx;
  logic [TAG_W-1:0]  fill_tag, wr_tag, p_tag;
  logic              fill_acc, wr_acc, wr_hit_t, probe_acc, ack_acc;
  logic              lk_hit, lk_perm, lk_dirty, cap_to_n, cap_to_b;
  logic [2:0]        report;
  logic              unused_addr_bits;

  assign fill_idx = fill_addr_i[OFFSET_W+IDX_W-1:OFFSET_W];
  assign fill_tag = fill_addr_i[ADDR_W-1:OFFSET_W+IDX_W];
  assign wr_idx   = wr_addr_i[OFFSET_W+IDX_W-1:OFFSET_W];
  assign wr_tag   = wr_addr_i[ADDR_W-1:OFFSET_W+IDX_W];
  assign p_idx    = pline_q[IDX_W-1:0];
  assign p_tag    = pline_q[LINE_W-1:IDX_W];
  assign unused_addr_bits = ^{fill_addr_i[OFFSET_W-1:0], wr_addr_i[OFFSET_W-1:0],
                              probe_req_addr_i[OFFSET_W-1:0]};

  assign fill_ready_o      = (state_q == S_IDLE);
  assign wr_ready_o        = (state_q == S_IDLE) && !fill_valid_i;
  assign probe_req_ready_o = (state_q == S_IDLE);
  assign fill_acc  = fill_valid_i && fill_ready_o;
  assign wr_acc    = wr_valid_i && wr_ready_o;
  assign probe_acc = probe_req_valid_i && probe_req_ready_o;
  assign ack_acc   = (state_q == S_ACK) && probe_ack_ready_i;
  assign wr_hit_t  = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag) && perm_q[wr_idx];

  // Caps 3..7 are not legal TileLink caps and fall into the toN class.
  assign cap_to_b = (pcap_q == 3'd1);
  assign cap_to_n = (pcap_q != 3'd0) && !cap_to_b;
  assign lk_hit   = valid_q[p_idx] && (tag_q[p_idx] == p_tag);
  assign lk_perm  = perm_q[p_idx];
  assign lk_dirty = dirty_q[p_idx];

  always_comb begin
    report = PARAM_NTON;
    if (lk_hit) begin
      if (!lk_perm)      report = cap_to_n ? PARAM_BTON : PARAM_BTOB;
      else if (cap_to_n) report = PARAM_TTON;
      else if (cap_to_b) report = PARAM_TTOB;
      else               report = PARAM_TTOT;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (probe_acc) state_d = S_LOOKUP;
      S_LOOKUP: state_d = S_ACK;
      S_ACK:    if (probe_ack_ready_i) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pline_q    <= '0;
      pcap_q     <= '0;
      ack_addr_q <= '0;
      ack_perm_q <= '0;
      ack_has_q  <= 1'b0;
      ack_data_q <= '0;
      dg_inval_q <= 1'b0;
      dg_tob_q   <= 1'b0;
      dg_clean_q <= 1'b0;
      wr_hit_q   <= 1'b0;
      valid_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_hit_q <= wr_acc && wr_hit_t;
      if (probe_acc) begin
        pline_q <= probe_req_addr_i[ADDR_W-1:OFFSET_W];
        pcap_q  <= probe_req_permissions_i;
      end
      if (state_q == S_LOOKUP) begin
        ack_addr_q <= {pline_q, {OFFSET_W{1'b0}}};
        ack_perm_q <= report;
        ack_has_q  <= lk_hit && lk_dirty;
        ack_data_q <= (lk_hit && lk_dirty) ? data_q[p_idx] : '0;
        dg_inval_q <= lk_hit && cap_to_n;
        dg_tob_q   <= lk_hit && lk_perm && cap_to_b;
        dg_clean_q <= lk_hit && lk_dirty;
      end
      if (fill_acc)                valid_q[fill_idx] <= 1'b1;
      if (ack_acc && dg_inval_q)   valid_q[p_idx]    <= 1'b0;
    end
  end

  // Payload arrays need no reset: every read is qualified by valid_q.
  always_ff @(posedge clk) begin
    if (fill_acc) begin
      tag_q[fill_idx]   <= fill_tag;
      perm_q[fill_idx]  <= fill_perm_i;
      dirty_q[fill_idx] <= 1'b0;
      data_q[fill_idx]  <= fill_data_i;
    end else if (wr_acc && wr_hit_t) begin
      data_q[wr_idx]  <= wr_data_i;
      dirty_q[wr_idx] <= 1'b1;
    end
    if (ack_acc) begin
      if (dg_tob_q)   perm_q[p_idx]  <= 1'b0;
      if (dg_clean_q) dirty_q[p_idx] <= 1'b0;
    end
  end

  assign wr_hit_o                = wr_hit_q;
  assign probe_ack_valid_o       = (state_q == S_ACK);
  assign probe_ack_addr_o        = ack_addr_q;
  assign probe_ack_permissions_o = ack_perm_q;
  assign probe_ack_has_data_o    = ack_has_q;
  assign probe_ack_dirty_data_o  = ack_data_q;

endmodule
`default_nettype wire

// File: tb/tb_tidc_l1_probe_agent.sv
`default_nettype none
// ============================================================================
// Module   : tb_tidc_l1_probe_agent
// Brief    : Directed + randomized bench with a line-table reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tidc_l1_probe_agent;
  localparam int ADDR_W = 64, DATA_W = 512, OFFSET_W = 6, IDX_W = 4;
  localparam int SETS = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  logic fill_valid_i = 0, fill_perm_i = 0, wr_valid_i = 0, probe_req_valid_i = 0;
  logic probe_ack_ready_i = 0;
  logic [ADDR_W-1:0] fill_addr_i = '0, wr_addr_i = '0, probe_req_addr_i = '0;
  logic [DATA_W-1:0] fill_data_i = '0, wr_data_i = '0;
  logic [2:0] probe_req_permissions_i = '0;
  logic fill_ready_o, wr_ready_o, wr_hit_o, probe_req_ready_o, probe_ack_valid_o, probe_ack_has_data_o;
  logic [ADDR_W-1:0] probe_ack_addr_o;
  logic [2:0] probe_ack_permissions_o;
  logic [DATA_W-1:0] probe_ack_dirty_data_o;

  tidc_l1_probe_agent #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OFFSET_W(OFFSET_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .fill_valid_i(fill_valid_i), .fill_ready_o(fill_ready_o), .fill_addr_i(fill_addr_i),
    .fill_data_i(fill_data_i), .fill_perm_i(fill_perm_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .wr_hit_o(wr_hit_o),
    .probe_req_valid_i(probe_req_valid_i), .probe_req_ready_o(probe_req_ready_o),
    .probe_req_addr_i(probe_req_addr_i), .probe_req_permissions_i(probe_req_permissions_i),
    .probe_ack_valid_o(probe_ack_valid_o), .probe_ack_ready_i(probe_ack_ready_i),
    .probe_ack_addr_o(probe_ack_addr_o), .probe_ack_permissions_o(probe_ack_permissions_o),
    .probe_ack_has_data_o(probe_ack_has_data_o), .probe_ack_dirty_data_o(probe_ack_dirty_data_o)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic chk_en = 1'b0;

  task automatic check(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W+IDX_W-1:OFFSET_W];
  endfunction
  function automatic logic [ADDR_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
    return a >> (OFFSET_W + IDX_W);
  endfunction

  // Reference model: table of lines plus one outstanding probe with its precomputed answer.
  logic              m_valid [SETS];
  logic [ADDR_W-1:0] m_tag   [SETS];
  logic              m_perm  [SETS];
  logic              m_dirty [SETS];
  logic [DATA_W-1:0] m_data  [SETS];
  logic              m_pend, m_wait, m_seen, m_dg_n, m_dg_b, m_dg_c;
  logic [IDX_W-1:0]  m_pidx;
  logic              e_wr_hit, e_has;
  logic [2:0]        e_perm;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_data;

  logic f_acc, w_acc, p_acc, a_acc, w_hit, v, pm, d, hit, to_n;
  logic [IDX_W-1:0] w_i, p_i, f_i;
  logic [ADDR_W-1:0] t;
  logic [DATA_W-1:0] dat;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SETS; i++) m_valid[i] <= 1'b0;
      m_pend <= 0; m_wait <= 0; m_seen <= 0; e_wr_hit <= 0;
      e_has <= 0; e_perm <= '0; e_addr <= '0; e_data <= '0;
      m_dg_n <= 0; m_dg_b <= 0; m_dg_c <= 0; m_pidx <= '0;
    end else begin
      f_acc = !m_pend && fill_valid_i;
      w_acc = !m_pend && wr_valid_i && !fill_valid_i;
      p_acc = !m_pend && probe_req_valid_i;
      a_acc = m_pend && !m_wait && probe_ack_ready_i;
      f_i = idx_of(fill_addr_i);
      w_i = idx_of(wr_addr_i);
      w_hit = m_valid[w_i] && m_tag[w_i] == tag_of(wr_addr_i) && m_perm[w_i];
      e_wr_hit <= w_acc && w_hit;
      // The probe sees the table as it is after this edge's fill/store.
      p_i = idx_of(probe_req_addr_i);
      v = m_valid[p_i]; t = m_tag[p_i]; pm = m_perm[p_i]; d = m_dirty[p_i]; dat = m_data[p_i];
      if (f_acc && f_i == p_i) begin
        v = 1; t = tag_of(fill_addr_i); pm = fill_perm_i; d = 0; dat = fill_data_i;
      end else if (w_acc && w_hit && w_i == p_i) begin
        d = 1; dat = wr_data_i;
      end
      if (f_acc) begin
        m_valid[f_i] <= 1; m_tag[f_i] <= tag_of(fill_addr_i); m_perm[f_i] <= fill_perm_i;
        m_dirty[f_i] <= 0; m_data[f_i] <= fill_data_i;
      end else if (w_acc && w_hit) begin
        m_dirty[w_i] <= 1; m_data[w_i] <= wr_data_i;
      end
      if (p_acc) begin
        hit  = v && t == tag_of(probe_req_addr_i);
        to_n = probe_req_permissions_i >= 3'd2;
        if (!hit)     e_perm <= 3'd5;
        else if (!pm) e_perm <= to_n ? 3'd2 : 3'd4;
        else          e_perm <= to_n ? 3'd1 : (probe_req_permissions_i == 3'd1 ? 3'd0 : 3'd3);
        e_has  <= hit && d;
        e_data <= (hit && d) ? dat : '0;
        e_addr <= probe_req_addr_i & ~64'h3f;
        m_dg_n <= hit && to_n;
        m_dg_b <= hit && pm && probe_req_permissions_i == 3'd1;
        m_dg_c <= hit && d;
        m_pidx <= p_i;
        m_pend <= 1; m_wait <= 1; m_seen <= 1;
      end else if (m_pend && m_wait) begin
        m_wait <= 0;
      end else if (a_acc) begin
        m_pend <= 0;
        if (m_dg_n) m_valid[m_pidx] <= 0;
        if (m_dg_b) m_perm[m_pidx]  <= 0;
        if (m_dg_c) m_dirty[m_pidx] <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", probe_req_ready_o, !m_pend);
      check("fill_ready", fill_ready_o, !m_pend);
      check("wr_ready", wr_ready_o, !m_pend && !fill_valid_i);
      check("wr_hit", wr_hit_o, e_wr_hit);
      check("ack_valid", probe_ack_valid_o, m_pend && !m_wait);
      if ((m_pend && !m_wait) || !m_seen) begin
        check("ack_addr", probe_ack_addr_o, e_addr);
        check("ack_perm", probe_ack_permissions_o, e_perm);
        check("ack_has_data", probe_ack_has_data_o, e_has);
        check("ack_data", probe_ack_dirty_data_o, e_data);
      end
    end
  end

  task automatic do_fill(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] dd, input logic p);
    fill_addr_i = a; fill_data_i = dd; fill_perm_i = p; fill_valid_i = 1;
    @(posedge clk); #1 fill_valid_i = 0;
  endtask

  task automatic do_store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] dd, input logic exp_hit);
    wr_addr_i = a; wr_data_i = dd; wr_valid_i = 1;
    @(posedge clk); #1 wr_valid_i = 0;
    @(negedge clk);
    check("lit_wr_hit", wr_hit_o, exp_hit);
    @(posedge clk); #1;
  endtask

  // Issues one probe, checks the ack literally, then completes it (optionally after a 5-cycle stall).
  task automatic do_probe(input logic [ADDR_W-1:0] a, input logic [2:0] cap, input logic [2:0] x_perm,
                          input logic x_has, input logic [DATA_W-1:0] x_data, input bit hold);
    int n;
    probe_req_addr_i = a; probe_req_permissions_i = cap; probe_req_valid_i = 1;
    probe_ack_ready_i = !hold;
    @(posedge clk); #1 probe_req_valid_i = 0;
    n = 0;
    @(negedge clk);
    while (!probe_ack_valid_o && n < 8) begin n++; @(negedge clk); end
    check("lit_ack_latency", n, 1);
    check("lit_ack_addr", probe_ack_addr_o, a & ~64'h3f);
    check("lit_ack_perm", probe_ack_permissions_o, x_perm);
    check("lit_ack_has", probe_ack_has_data_o, x_has);
    check("lit_ack_data", probe_ack_dirty_data_o, x_data);
    if (hold) begin
      repeat (5) begin
        @(negedge clk);
        check("lit_hold_valid", probe_ack_valid_o, 1'b1);
        check("lit_hold_perm", probe_ack_permissions_o, x_perm);
        check("lit_hold_req_ready", probe_req_ready_o, 1'b0);
        check("lit_hold_fill_ready", fill_ready_o, 1'b0);
      end
      probe_ack_ready_i = 1;
    end
    @(posedge clk); #1 probe_ack_ready_i = 0;
    @(negedge clk);
    check("lit_req_ready_after_ack", probe_req_ready_o, 1'b1);
    @(posedge clk); #1;
  endtask

  function automatic logic [DATA_W-1:0] rand_line();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [ADDR_W-1:0] rand_addr();
    logic [ADDR_W-1:0] a;
    a = '0;
    a[5:0]   = 6'($urandom);
    a[9:6]   = 4'($urandom_range(0, 3));
    a[11:10] = 2'($urandom_range(0, 2));
    return a;
  endfunction

  logic [DATA_W-1:0] pat;
  int n;

  initial begin
    pat = {8{64'hABCDEF0123456789}};
    repeat (3) @(posedge clk);
    #1 rst_n = 1; chk_en = 1;
    @(negedge clk);
    check("lit_reset_req_ready", probe_req_ready_o, 1'b1);
    check("lit_reset_ack_valid", probe_ack_valid_o, 1'b0);
    check("lit_reset_wr_hit", wr_hit_o, 1'b0);
    @(posedge clk); #1;

    do_probe(64'h1000, 3'd2, 3'd5, 0, '0, 0);
    do_fill(64'h1000, rand_line(), 1'b0);
    do_probe(64'h1000, 3'd2, 3'd2, 0, '0, 0);
    do_probe(64'h1000, 3'd2, 3'd5, 0, '0, 0);
    do_fill(64'h1000, rand_line(), 1'b1);
    do_store(64'h1000, pat, 1'b1);
    do_probe(64'h1000, 3'd1, 3'd0, 1, pat, 0);
    do_store(64'h1000, rand_line(), 1'b0);
    do_probe(64'h1000, 3'd2, 3'd2, 0, '0, 0);
    do_fill(64'h1000, rand_line(), 1'b1);
    do_fill(64'h2000, rand_line(), 1'b0);
    do_probe(64'h1000, 3'd2, 3'd5, 0, '0, 0);
    do_probe(64'h2000, 3'd0, 3'd4, 0, '0, 0);
    do_fill(64'h3040, rand_line(), 1'b1);
    do_probe(64'h3040, 3'd0, 3'd3, 0, '0, 1);
    do_fill(64'h4080, rand_line(), 1'b1);
    do_probe(64'h4080, 3'd6, 3'd1, 0, '0, 0);

    // Reset while an ack is pending.
    do_fill(64'h1000, rand_line(), 1'b1);
    probe_req_addr_i = 64'h1000; probe_req_permissions_i = 3'd0; probe_req_valid_i = 1;
    @(posedge clk); #1 probe_req_valid_i = 0;
    n = 0;
    while (!probe_ack_valid_o && n < 8) begin n++; @(posedge clk); #1; end
    check("lit_pre_reset_ack_valid", probe_ack_valid_o, 1'b1);
    rst_n = 0;
    #1 check("lit_reset_drops_ack", probe_ack_valid_o, 1'b0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1;
    do_probe(64'h1000, 3'd2, 3'd5, 0, '0, 0);

    for (int c = 0; c < 3000; c++) begin
      fill_valid_i = ($urandom_range(0, 3) == 0);
      fill_addr_i = rand_addr(); fill_data_i = rand_line(); fill_perm_i = 1'($urandom);
      wr_valid_i = ($urandom_range(0, 2) == 0);
      wr_addr_i = rand_addr(); wr_data_i = rand_line();
      probe_req_valid_i = ($urandom_range(0, 2) == 0);
      probe_req_addr_i = rand_addr(); probe_req_permissions_i = 3'($urandom);
      probe_ack_ready_i = 1'($urandom);
      @(posedge clk); #1;
    end
    fill_valid_i = 0; wr_valid_i = 0; probe_req_valid_i = 0; probe_ack_ready_i = 1;
    repeat (4) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/tidc_l1_probe_agent.md
# tidc_l1_probe_agent

L1-side coherence agent for the TIDC system: the responder end of the hub's probe channel. It tracks per-line permission (T/B), dirty state and data for a small direct-mapped line table. It answers each probe request with the correct TileLink shrink/report parameter and any dirty data, then downgrades its own copy. It sits between an L1 adapter's probe_req/probe_ack ports and the L1 fill/store datapath, replacing the fixed "always BtoN" probe stub used in bring-up benches.

## Interface
- ADDR_W, 64, address width
- DATA_W, 512, line width (64-byte lines)
- OFFSET_W, 6, line-offset bits
- IDX_W, 4, table index bits (SETS = 2^IDX_W = 16)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- fill_valid  in  1  install line (grant data arrived)
- fill_ready  out  1  fill accepted when valid&&ready
- fill_addr  in  ADDR_W  line address
- fill_data  in  DATA_W  line data
- fill_perm  in  1  1 = T (exclusive), 0 = B (shared)
- wr_valid  in  1  local store of full line
- wr_ready  out  1  store accepted when valid&&ready
- wr_addr  in  ADDR_W  store address
- wr_data  in  DATA_W  store data
- wr_hit  out  1  one-cycle pulse, cycle after accept: store hit a T line
- probe_req_valid  in  1  probe from hub
- probe_req_ready  out  1  agent idle
- probe_req_addr  in  ADDR_W  probed address
- probe_req_permissions  in  3  cap: toT=0, toB=1, toN=2
- probe_ack_valid  out  1  response valid, held until accepted
- probe_ack_ready  in  1  hub accepts ack
- probe_ack_addr  out  ADDR_W  probed address, low OFFSET_W bits zeroed
- probe_ack_permissions  out  3  report: TtoB=0, TtoN=1, BtoN=2, TtoT=3, BtoB=4, NtoN=5 (PARAM_* in tidc_params.v)
- probe_ack_has_data  out  1  ack carries dirty data
- probe_ack_dirty_data  out  DATA_W  line data if has_data, else 0

## Operation
- Index = addr[OFFSET_W+IDX_W-1:OFFSET_W]; tag = addr[ADDR_W-1:OFFSET_W+IDX_W]. Entry = {valid, tag, perm, dirty, data}.
- FSM states:
  - IDLE: probe_req_ready=1, fill_ready=1, wr_ready=!fill_valid. Probe handshake -> LOOKUP; latch addr and cap.
  - LOOKUP: read the entry, compute the report, load ack regs -> ACK.
  - ACK: probe_ack_valid=1; on probe_ack_ready, apply the downgrade -> IDLE.
- Hit = valid && tag match.
- Report rules:
  - Miss: NtoN, no data.
  - B hit: cap toN -> BtoN; otherwise BtoB.
  - T hit: toN -> TtoN; toB -> TtoB; toT -> TtoT.
- has_data = hit && dirty.
- Downgrade on ack handshake:
  - toN: valid <= 0.
  - T with toB: perm <= B.
  - has_data: dirty <= 0.
  - Miss: no change.
- Fill: writes the whole entry; valid=1, dirty=0, tag/perm/data from inputs. A fill overwrites any previous occupant of the set (silent eviction; writeback is the adapter's job).
- Store:
  - Hit with perm T: data <= wr_data, dirty <= 1, wr_hit pulse.
  - Otherwise: no table change, no pulse.
- Same-cycle fill and store: the fill is accepted and the store stalls (wr_ready=0).
- Fill or store accepted in the same cycle as a probe handshake: the table write lands at that edge, and LOOKUP sees the updated entry.
- Illegal cap values (3-7): treated as toN.

## Timing
- Probe handshake at edge N -> probe_ack_valid high from cycle N+2. Ack outputs stay stable while valid && !ready.
- Ack handshake at edge M -> probe_req_ready high in cycle M+1. Maximum throughput is one probe per 3 cycles.
- Fill and store commit at the accepting edge. wr_hit is high for the one cycle after acceptance.
- Reset (asynchronous, any state):
  - FSM returns to IDLE; all valid bits clear.
  - probe_ack_valid, has_data and wr_hit go to 0; ack addr/permissions/data go to 0.
  - Ready outputs are 1 after reset deassertion.
- Reset during ACK drops the pending ack; the hub must reissue the probe.

## Test plan
- After reset, probe 0x1000 cap toN -> ack at N+2: addr 0x1000, NtoN, has_data=0, data 0.
- Fill 0x1000 perm B, then probe 0x1000 toN -> BtoN, has_data=0. Re-probe -> NtoN.
- Fill 0x1000 perm T, store 0x1000 with 0xABCD…89 pattern (wr_hit=1), probe toB:
  - Ack is TtoB, has_data=1, data = the pattern.
  - A following store to 0x1000 gives wr_hit=0. Probe toN -> BtoN, has_data=0.
- Fill 0x1000 T, fill 0x2000 B (same index 0, tag 0x8):
  - Probe 0x1000 -> NtoN; probe 0x2000 toT -> BtoB.
- Hold probe_ack_ready=0 for 5 cycles: ack fields stable, probe_req_ready=0, fill_ready=0. Release -> IDLE next cycle.
- Assert rst_n=0 during ACK -> probe_ack_valid drops immediately. Probe 0x1000 after release -> NtoN.
